// File: rtl/pipe_rca_pkg.sv
// Shared constants and helpers for the segmented, pipelined ripple-carry adder.
package pipe_rca_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefSeg   = 4;

  function automatic int unsigned num_stages(int unsigned width, int unsigned seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/seg_adder.sv
// Combinational SEG-bit ripple-carry adder made of full-adder cells.
module seg_adder
  import pipe_rca_pkg::*;
#(
  parameter int unsigned SEG = DefSeg
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cmsb
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co   = c[SEG];
  // Carry into the MSB; only the top segment's value feeds overflow detection.
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined adder/subtractor: one SEG-bit ripple segment per stage, valid/ready handshake.
module pipe_rca_adder
  import pipe_rca_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG   = DefSeg
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipe_rca_adder: WIDTH must be a multiple of SEG");
  end

  // Stage registers; b is stored already conditioned for subtraction.
  logic             v_q  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             c_q  [STAGES];
  logic             cm_q [STAGES];

  // Per-stage inputs (stage 0 from the ports, stage k from stage k-1).
  logic             v_in [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];

  logic [SEG-1:0]   seg_s  [STAGES];
  logic             seg_co [STAGES];
  logic             seg_cm [STAGES];

  logic stall;

  assign stall    = v_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    v_in[0] = in_valid && in_ready;
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub | cin;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k]                = s_in[k];
      s_nx[k][k*SEG +: SEG]  = seg_s[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    seg_adder #(
      .SEG (SEG)
    ) u_seg (
      .a    (a_in[k][k*SEG +: SEG]),
      .b    (b_in[k][k*SEG +: SEG]),
      .ci   (c_in[k]),
      .s    (seg_s[k]),
      .co   (seg_co[k]),
      .cmsb (seg_cm[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        cm_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= v_in[k];
        a_q[k]  <= a_in[k];
        b_q[k]  <= b_in[k];
        s_q[k]  <= s_nx[k];
        c_q[k]  <= seg_co[k];
        cm_q[k] <= seg_cm[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = c_q[STAGES-1] ^ cm_q[STAGES-1];

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Bench for pipe_rca_adder: runs the same directed suite on SEG=4 and SEG=16 instances.
module tb_pipe_rca_adder;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_s     [2];
  logic         in_valid, out_ready, cin, sub;
  logic [W-1:0] a, b;
  logic         in_ready_s  [2];
  logic         out_valid_s [2];
  logic         cout_s      [2];
  logic         ovf_s       [2];
  logic [W-1:0] sum_s       [2];

  logic         o_ready, o_valid, o_cout, o_ovf;
  logic [W-1:0] o_sum;

  int cur = 0;
  int lat = 4;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  rec_t           seen  [$];
  int             acc   [$];
  logic [W+1:0]   exp_q [$];
  logic           prev_stall = 1'b0;
  logic [W+1:0]   prev_out;

  pipe_rca_adder #(
    .WIDTH (W),
    .SEG   (4)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n_s[0]),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s[0]),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid_s[0]),
    .out_ready (out_ready),
    .sum       (sum_s[0]),
    .cout      (cout_s[0]),
    .ovf       (ovf_s[0])
  );

  pipe_rca_adder #(
    .WIDTH (W),
    .SEG   (16)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n_s[1]),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s[1]),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid_s[1]),
    .out_ready (out_ready),
    .sum       (sum_s[1]),
    .cout      (cout_s[1]),
    .ovf       (ovf_s[1])
  );

  // The inactive instance is held in reset; observe only the active one.
  assign o_ready = (cur == 1) ? in_ready_s[1]  : in_ready_s[0];
  assign o_valid = (cur == 1) ? out_valid_s[1] : out_valid_s[0];
  assign o_sum   = (cur == 1) ? sum_s[1]       : sum_s[0];
  assign o_cout  = (cur == 1) ? cout_s[1]      : cout_s[0];
  assign o_ovf   = (cur == 1) ? ovf_s[1]       : ovf_s[0];

  always @(posedge clk) cyc <= cyc + 1;

  // Golden model: {cout, ovf, sum} from wide unsigned and signed integer arithmetic.
  function automatic logic [W+1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   full;
    int           c;
    int           sr;
    logic         ov;
    yy   = sb ? ~y : y;
    c    = sb ? 1 : int'(ci);
    full = {1'b0, x} + {1'b0, yy} + 17'(c);
    sr   = int'($signed(x)) + int'($signed(yy)) + c;
    ov   = (sr > 32767) || (sr < -32768);
    return {full[W], ov, full[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (dut %0d, cycle %0d)",
               name, act, req, cur, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n_s[cur]) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", {31'd0, o_ready}, {31'd0, !(o_valid && !out_ready)});
      if (prev_stall) begin
        chk("stall_valid_hold", {31'd0, o_valid}, 32'd1);
        chk("stall_data_hold", {14'd0, o_cout, o_ovf, o_sum}, {14'd0, prev_out});
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", {31'd0, o_valid}, 32'd0);
        end else begin
          chk("result", {14'd0, o_cout, o_ovf, o_sum}, {14'd0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && o_ready) exp_q.push_back(calc(a, b, cin, sub));
      prev_stall = o_valid && !out_ready;
      prev_out   = {o_cout, o_ovf, o_sum};
    end
  end

  task automatic step();
    @(negedge clk);
    if (rst_n_s[cur] && in_valid && o_ready) acc.push_back(cyc);
    if (rst_n_s[cur] && o_valid && out_ready) seen.push_back('{o_sum, o_cout, o_ovf, cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    sub      = sb;
  endtask

  task automatic wait_seen(input int want);
    int n;
    n = 0;
    while (seen.size() < want && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic chk_rec(input string name, input int idx, input logic [W-1:0] s,
                         input logic c, input logic o);
    if (seen.size() > idx) begin
      chk({name, "_sum"}, {16'd0, seen[idx].s}, {16'd0, s});
      chk({name, "_cout"}, {31'd0, seen[idx].c}, {31'd0, c});
      chk({name, "_ovf"}, {31'd0, seen[idx].o}, {31'd0, o});
    end
  endtask

  task automatic run_suite();
    logic [3:0] pat;
    int         n;
    pat = 4'b1001;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n_s[cur] = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_sum", {16'd0, o_sum}, 32'd0);
    chk("rst_cout", {31'd0, o_cout}, 32'd0);
    chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
    rst_n_s[cur] = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, o_ready}, 32'd1);
    step();

    // Single addition with a carry across segments.
    seen.delete(); acc.delete();
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    wait_seen(1);
    chk("t1_count", seen.size(), 32'd1);
    chk_rec("t1", 0, 16'h0100, 1'b0, 1'b0);
    if (seen.size() > 0 && acc.size() > 0) chk("t1_latency", seen[0].cyc - acc[0], lat);

    // Back-to-back: wraparound then signed overflow.
    seen.delete(); acc.delete();
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    wait_seen(2);
    chk("t2_count", seen.size(), 32'd2);
    chk_rec("t2a", 0, 16'h0000, 1'b1, 1'b0);
    chk_rec("t2b", 1, 16'h8000, 1'b0, 1'b1);
    if (seen.size() > 1 && acc.size() > 0) begin
      chk("t2_latency", seen[0].cyc - acc[0], lat);
      chk("t2_spacing", seen[1].cyc - seen[0].cyc, 32'd1);
    end

    // Subtraction: borrow case (cin ignored) and signed overflow case.
    seen.delete(); acc.delete();
    drive(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    wait_seen(2);
    chk("t3_count", seen.size(), 32'd2);
    chk_rec("t3a", 0, 16'hFFFE, 1'b0, 1'b0);
    chk_rec("t3b", 1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure stream with out_ready cycling 1,0,0,1.
    seen.delete(); acc.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), W'(i), 1'b0, 1'b0);
      n = 0;
      do begin
        out_ready = pat[cyc % 4];
        step();
        n++;
      end while (acc.size() < i && n < 20);
    end
    in_valid = 1'b0;
    n = 0;
    while (seen.size() < 8 && n < 80) begin
      out_ready = pat[cyc % 4];
      step();
      n++;
    end
    out_ready = 1'b1;
    repeat (2 * lat + 2) step();
    chk("bp_count", seen.size(), 32'd8);
    foreach (seen[j]) chk("bp_sum_order", {16'd0, seen[j].s}, 2 * (j + 1));

    // Reset with operands in flight and a stalled result at the output.
    seen.delete(); acc.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(16'h0101 * (i + 1)), 16'h0011, 1'b0, 1'b0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin
      step();
      n++;
    end
    chk("mid_pre_valid", {31'd0, o_valid}, 32'd1);
    rst_n_s[cur] = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, o_sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, o_cout}, 32'd0);
    chk("mid_rst_ovf", {31'd0, o_ovf}, 32'd0);
    @(posedge clk);
    #1;
    rst_n_s[cur] = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    seen.delete(); acc.delete();
    out_ready = 1'b1;
    repeat (8) step();
    chk("no_stale", seen.size(), 32'd0);
    drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    wait_seen(1);
    chk("post_rst_count", seen.size(), 32'd1);
    chk_rec("post_rst", 0, 16'h5556, 1'b0, 1'b0);
    if (seen.size() > 0 && acc.size() > 0) chk("post_rst_latency", seen[0].cyc - acc[0], lat);

    repeat (lat + 2) step();
    chk("model_drained", exp_q.size(), 32'd0);
    rst_n_s[cur] = 1'b0;
    step();
  endtask

  initial begin
    rst_n_s[0] = 1'b0;
    rst_n_s[1] = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;

    chk("model_add", {14'd0, calc(16'h00FF, 16'h0001, 1'b0, 1'b0)}, {14'd0, 2'b00, 16'h0100});
    chk("model_wrap", {14'd0, calc(16'hFFFF, 16'h0001, 1'b0, 1'b0)}, {14'd0, 2'b10, 16'h0000});
    chk("model_ovf", {14'd0, calc(16'h7FFF, 16'h0001, 1'b0, 1'b0)}, {14'd0, 2'b01, 16'h8000});
    chk("model_sub", {14'd0, calc(16'h0005, 16'h0007, 1'b1, 1'b1)}, {14'd0, 2'b00, 16'hFFFE});
    chk("model_sub_ovf", {14'd0, calc(16'h8000, 16'h0001, 1'b0, 1'b1)}, {14'd0, 2'b11, 16'h7FFF});

    for (int d = 0; d < 2; d++) begin
      cur = d;
      lat = (d == 1) ? 1 : 4;
      run_suite();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_rca_adder.md
PIPE_RCA_ADDER -- requirements
Module: pipe_rca_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter SEG, default 4: ripple segment width in bits; the stage count is STAGES = WIDTH/SEG.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 in_valid  input  1: operand set present this cycle.
REQ-006 in_ready  output  1: block accepts operands this cycle.
REQ-007 a  input  WIDTH: operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH: operand B.
REQ-009 cin  input  1: carry-in; ignored when sub=1.
REQ-010 sub  input  1: 0 selects A+B+cin; 1 selects A-B.
REQ-011 out_valid  output  1: result present.
REQ-012 out_ready  input  1: downstream accepts the result.
REQ-013 sum  output  WIDTH: result bits.
REQ-014 cout  output  1: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-015 ovf  output  1: signed two's-complement overflow.

Function
REQ-016 Operation: sum = A + (sub ? ~B : B) + (sub ? 1 : cin), computed modulo 2^WIDTH.
REQ-017 Carry-out and overflow rules:
- cout = bit WIDTH of the full result.
- ovf = carry into the MSB XOR carry out of the MSB.
REQ-018 Pipeline organisation:
- STAGES register stages.
- Stage k adds segment k, bits [k*SEG +: SEG], using the carry registered by stage k-1.
- Stage 0 uses the effective carry-in.
REQ-019 Unprocessed upper operand segments and completed lower sum segments are carried forward in stage registers, so that each result is aligned at the output.
REQ-020 A transfer occurs on any cycle with in_valid && in_ready, or with out_valid && out_ready.
REQ-021 Latency: an accepted operand set appears on sum/cout/ovf with out_valid=1 exactly STAGES cycles later when no stall occurs.
REQ-022 Stall condition: stall = out_valid && !out_ready.
- Under stall, every stage holds, including its valid bit.
- in_ready = !stall.
REQ-023 When not stalled, each stage advances every cycle.
- Each stage's valid bit takes the previous stage's valid bit.
- Stage 0's valid bit takes in_valid && in_ready.
REQ-024 Throughput is one result per cycle with out_ready held at 1, including back-to-back inputs.
REQ-025 Results leave in acceptance order, with no loss and no duplication under any out_ready pattern.
REQ-026 sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
REQ-027 Bubbles: a cycle with in_valid=0 inserts an invalid slot. The data content of invalid slots is don't-care, but out_valid shall be 0 for them.
REQ-028 SEG=WIDTH gives a single stage with latency 1.
REQ-029 WIDTH not divisible by SEG is a parameter error and shall be flagged at elaboration.

Reset
REQ-030 rst_n=0 shall immediately, asynchronously:
- clear all stage valid bits;
- drive out_valid=0, sum=0, cout=0, ovf=0.
REQ-031 Reset in the middle of an operation discards all in-flight operands.
REQ-032 in_ready shall be 1 from the first cycle after rst_n deasserts.

Structure
REQ-033 Shared package pipe_rca_pkg shall hold:
- default WIDTH/SEG constants;
- the stage-count function WIDTH/SEG.
REQ-034 One sub-module, seg_adder, parameterised by SEG:
- purely combinational SEG-bit ripple-carry adder built from full-adder cells;
- inputs a, b, ci; outputs s, co, and the carry into its MSB (used for ovf in the top segment).
REQ-035 Only pipe_rca_adder holds registers; seg_adder holds none.

Verification (WIDTH=16, SEG=4, latency 4)
REQ-036 a=0x00FF, b=0x0001, cin=0, sub=0 -> 4 cycles later: sum=0x0100, cout=0, ovf=0.
REQ-037 a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0; then a=0x7FFF, b=0x0001 on the next cycle -> sum=0x8000, cout=0, ovf=1, one cycle after the first result.
REQ-038 sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0; sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-039 Backpressure stream:
- 8 back-to-back additions (a=i, b=i, i=1..8), with out_ready toggling 1,0,0,1,...
- Required: sums 2,4,...,16 in order, each exactly once; in_ready=0 on every stalled cycle; outputs hold during stalls.
REQ-040 Reset mid-operation:
- Accept 3 operand sets, then pulse rst_n=0 for 1 cycle.
- Required: out_valid falls at once; no stale result ever emerges; a new operand accepted after reset returns its correct sum 4 cycles later.
REQ-041 Every scenario shall be compared against a golden model computing (A + B' + c) at WIDTH+1 bits; the bench shall also repeat the suite with SEG=16 (latency 1).
